rf_write_arbiter: RTL and testbench



---
 rtl/rfw_pkg.sv | 26 ++
 rtl/rfw_queue.sv | 79 +++++++
 rtl/rf_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfw_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rfw_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } rfw_entry_t;

  typedef enum logic [2:0] {
    WIN_IDLE   = 3'd0,
    WIN_DRAIN  = 3'd1,
    WIN_ALU    = 3'd2,
    WIN_HEAD   = 3'd3,
    WIN_BYPASS = 3'd4
  } rfw_win_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

// File: rtl/rfw_queue.sv
// Load-result FIFO with broadcast kill of matching destinations.
// With RFW_PENDING_EN defined it also exports the set of live destinations.
module rfw_queue
  import rfw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  rfw_entry_t            i_entry,
  input  logic                  i_pop,
  input  logic                  i_kill_en,
  input  logic [REG_ADDR_W-1:0] i_kill_rd,
  output rfw_entry_t            o_head,
  output logic                  o_full,
  output logic                  o_empty
`ifdef RFW_PENDING_EN
  ,
  output logic [NUM_REGS-1:0]   o_live_mask
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  rfw_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_wr_idx  = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx  = r_rd_ptr[IDX_W-1:0];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
  assign o_head    = r_mem[w_rd_idx];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage and pointers; a popped slot is marked dead so live implies occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && (r_mem[i].rd == i_kill_rd)) begin
          r_mem[i].live <= 1'b0;
        end
      end
      if (w_do_pop) begin
        r_mem[w_rd_idx].live <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push) begin
        r_mem[w_wr_idx] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

`ifdef RFW_PENDING_EN
  // OR of the destinations of every live slot.
  always_comb begin
    o_live_mask = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      o_live_mask = o_live_mask |
                    (r_mem[i].live ? rd_onehot(r_mem[i].rd) : {NUM_REGS{1'b0}});
    end
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: ALU priority, queued loads, starvation drain
// and write-after-write cancellation. Optional macro RFW_PENDING_EN adds `pending`.
module rf_write_arbiter
  import rfw_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data
`ifdef RFW_PENDING_EN
  ,
  output logic [NUM_REGS-1:0]   pending
`endif
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]      r_starve;
  logic [CNT_W-1:0]      w_starve_nxt;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0]     r_write_data;

  rfw_win_e              w_win;
  rfw_entry_t            w_head;
  rfw_entry_t            w_push_entry;
  logic                  w_q_full;
  logic                  w_q_empty;
  logic                  w_force;
  logic                  w_ld_fire;
  logic                  w_alu_accept;
  logic                  w_kill_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_win_live;
  logic [REG_ADDR_W-1:0] w_win_rd;
  logic [DATA_W-1:0]     w_win_data;
  logic                  w_write_nxt;
`ifdef RFW_PENDING_EN
  logic [NUM_REGS-1:0]   w_live_mask;
`endif

  assign ld_ready     = !w_q_full;
  assign w_ld_fire    = ld_valid && !w_q_full;
  assign w_force      = !w_q_empty && (r_starve == CNT_W'(STARVE_MAX));
  assign alu_stall    = (w_win == WIN_DRAIN) && alu_valid;
  assign w_alu_accept = (w_win == WIN_ALU);
  assign w_kill_en    = w_alu_accept && (alu_rd != {REG_ADDR_W{1'b0}});
  // Loads that bypass, target x0, or tie with the accepted ALU rd never enter the queue.
  assign w_push       = w_ld_fire && (w_win != WIN_BYPASS) &&
                        (ld_rd != {REG_ADDR_W{1'b0}}) &&
                        !(w_alu_accept && (alu_rd == ld_rd));
  assign w_push_entry = '{live: 1'b1, rd: ld_rd, data: ld_data};
  assign w_write_nxt  = w_win_live && (w_win_rd != {REG_ADDR_W{1'b0}});

  assign reg_write    = r_reg_write;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;

  // Winner selection in fixed priority order.
  always_comb begin
    w_win = WIN_IDLE;
    if (w_force) begin
      w_win = WIN_DRAIN;
    end else if (alu_valid) begin
      w_win = WIN_ALU;
    end else if (!w_q_empty) begin
      w_win = WIN_HEAD;
    end else if (w_ld_fire) begin
      w_win = WIN_BYPASS;
    end else begin
      w_win = WIN_IDLE;
    end
  end

  // Winning write, queue pop and next starvation count.
  always_comb begin
    w_win_live   = 1'b0;
    w_win_rd     = {REG_ADDR_W{1'b0}};
    w_win_data   = {DATA_W{1'b0}};
    w_pop        = 1'b0;
    w_starve_nxt = {CNT_W{1'b0}};
    case (w_win)
      WIN_DRAIN, WIN_HEAD: begin
        w_win_live = w_head.live;
        w_win_rd   = w_head.rd;
        w_win_data = w_head.data;
        w_pop      = 1'b1;
      end
      WIN_ALU: begin
        w_win_live   = 1'b1;
        w_win_rd     = alu_rd;
        w_win_data   = alu_data;
        w_starve_nxt = w_q_empty ? {CNT_W{1'b0}} : (r_starve + CNT_W'(1));
      end
      WIN_BYPASS: begin
        w_win_live = 1'b1;
        w_win_rd   = ld_rd;
        w_win_data = ld_data;
      end
      default: begin
        w_win_live = 1'b0;
      end
    endcase
  end

  // Starvation counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve     <= {CNT_W{1'b0}};
      r_reg_write  <= 1'b0;
      r_write_reg  <= {REG_ADDR_W{1'b0}};
      r_write_data <= {DATA_W{1'b0}};
    end else begin
      r_starve    <= w_starve_nxt;
      r_reg_write <= w_write_nxt;
      if (w_write_nxt) begin
        r_write_reg  <= w_win_rd;
        r_write_data <= w_win_data;
      end
    end
  end

  rfw_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_entry   (w_push_entry),
    .i_pop     (w_pop),
    .i_kill_en (w_kill_en),
    .i_kill_rd (alu_rd),
    .o_head    (w_head),
    .o_full    (w_q_full),
    .o_empty   (w_q_empty)
`ifdef RFW_PENDING_EN
    ,
    .o_live_mask (w_live_mask)
`endif
  );

`ifdef RFW_PENDING_EN
  assign pending = w_live_mask;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
`ifdef RFW_PENDING_EN
  logic [31:0] pending;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data)
`ifdef RFW_PENDING_EN
    ,
    .pending    (pending)
`endif
  );

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  ment_t       m_q[$];
  int          m_starve = 0;
  bit          exp_stall;
  bit          exp_ready;
  logic        obs_stall;
  logic [31:0] rf_obs [32];

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
  endtask

`ifdef RFW_PENDING_EN
  function automatic logic [31:0] model_pending();
    logic [31:0] m = 32'd0;
    foreach (m_q[i]) if (m_q[i].live) m[m_q[i].rd] = 1'b1;
    return m;
  endfunction
`endif

  // One clock: check handshakes mid-cycle, advance the model, check the write port.
  task automatic step();
    bit fire, force_d, was_empty, alu_acc, bypass, wv;
    logic [4:0] wr;
    logic [31:0] wd;
    ment_t h;
    @(negedge clk);
    was_empty = (m_q.size() == 0);
    exp_ready = (m_q.size() < DEPTH);
    force_d   = !was_empty && (m_starve == STARVE_MAX);
    exp_stall = force_d && alu_valid;
    obs_stall = alu_stall;
    n_assert++;
    if (alu_stall !== exp_stall) begin
      n_fail++; $display("FAIL alu_stall: got %b expected %b at %0t", alu_stall, exp_stall, $time);
    end
    n_assert++;
    if (ld_ready !== exp_ready) begin
      n_fail++; $display("FAIL ld_ready: got %b expected %b at %0t", ld_ready, exp_ready, $time);
    end
    fire = ld_valid && exp_ready;
    alu_acc = 1'b0; bypass = 1'b0; wv = 1'b0; wr = 5'd0; wd = 32'd0;
    if (force_d) begin
      h = m_q.pop_front(); wv = h.live && (h.rd != 5'd0); wr = h.rd; wd = h.data; m_starve = 0;
    end else if (alu_valid) begin
      alu_acc = 1'b1; wv = (alu_rd != 5'd0); wr = alu_rd; wd = alu_data;
      m_starve = was_empty ? 0 : m_starve + 1;
    end else if (!was_empty) begin
      h = m_q.pop_front(); wv = h.live && (h.rd != 5'd0); wr = h.rd; wd = h.data; m_starve = 0;
    end else if (fire) begin
      bypass = 1'b1; wv = (ld_rd != 5'd0); wr = ld_rd; wd = ld_data;
    end
    if (alu_acc) foreach (m_q[i]) if (m_q[i].rd == alu_rd) m_q[i].live = 1'b0;
    if (fire && !bypass && (ld_rd != 5'd0) && !(alu_acc && (alu_rd == ld_rd)))
      m_q.push_back('{1'b1, ld_rd, ld_data});
    if (was_empty) m_starve = 0;
    @(posedge clk); #1;
    n_assert++;
    if (reg_write !== wv) begin
      n_fail++; $display("FAIL reg_write: got %b expected %b at %0t", reg_write, wv, $time);
    end
    if (wv) begin
      n_assert++;
      if (write_reg !== wr || write_data !== wd) begin
        n_fail++;
        $display("FAIL write_port: got x%0d=%h expected x%0d=%h at %0t", write_reg, write_data, wr, wd, $time);
      end
    end
    if (reg_write === 1'b1) rf_obs[write_reg] = write_data;
`ifdef RFW_PENDING_EN
    n_assert++;
    if (pending !== model_pending()) begin
      n_fail++; $display("FAIL pending: got %h expected %h at %0t", pending, model_pending(), $time);
    end
`endif
  endtask

  task automatic idle_inputs();
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 16 && m_q.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_assert++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_port: got %b x%0d=%h expected 0", reg_write, write_reg, write_data);
    end
    n_assert++;
    if (alu_stall !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_handshake: got stall=%b ready=%b expected 0/1", alu_stall, ld_ready);
    end
`ifdef RFW_PENDING_EN
    n_assert++;
    if (pending !== 32'd0) begin
      n_fail++; $display("FAIL reset_pending: got %h expected 0", pending);
    end
`endif
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    set_alu(1'b1, 5'd3, 32'h11); set_ld(1'b1, 5'd4, 32'h22);
    step();
    n_assert++;
    if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h11) begin
      n_fail++; $display("FAIL priority_alu: got %b x%0d=%h expected x3=11", reg_write, write_reg, write_data);
    end
    idle_inputs();
    step();
    n_assert++;
    if (reg_write !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h22) begin
      n_fail++; $display("FAIL priority_load: got %b x%0d=%h expected x4=22", reg_write, write_reg, write_data);
    end
  endtask

  task automatic test_bypass();
    set_ld(1'b1, 5'd7, 32'hAB);
    step();
    n_assert++;
    if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hAB) begin
      n_fail++; $display("FAIL bypass: got %b x%0d=%h expected x7=ab", reg_write, write_reg, write_data);
    end
    idle_inputs();
    step();
    n_assert++;
    if (reg_write !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL bypass_empty: got write=%b ready=%b expected 0/1", reg_write, ld_ready);
    end
  endtask

  task automatic test_starvation();
    int alu_wins;
    set_alu(1'b1, 5'd1, 32'h100); set_ld(1'b1, 5'd9, 32'h909);
    step();
    set_ld(1'b0, 5'd0, 32'd0);
    alu_wins = 0;
    for (int k = 0; k < STARVE_MAX; k++) begin
      set_alu(1'b1, 5'd10, 32'h200 + k);
      step();
      if (obs_stall === 1'b0 && reg_write === 1'b1 && write_reg === 5'd10) alu_wins++;
    end
    n_assert++;
    if (alu_wins != 4) begin
      n_fail++; $display("FAIL starve_alu_wins: got %0d expected 4", alu_wins);
    end
    set_alu(1'b1, 5'd10, 32'h55);
    step();
    n_assert++;
    if (obs_stall !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h909) begin
      n_fail++; $display("FAIL starve_drain: got stall=%b x%0d=%h expected 1 x9=909", obs_stall, write_reg, write_data);
    end
    step();
    n_assert++;
    if (obs_stall !== 1'b0 || write_reg !== 5'd10 || write_data !== 32'h55) begin
      n_fail++; $display("FAIL starve_held_alu: got stall=%b x%0d=%h expected 0 x10=55", obs_stall, write_reg, write_data);
    end
    drain();
  endtask

  task automatic test_cancel();
    set_alu(1'b1, 5'd1, 32'h1); set_ld(1'b1, 5'd5, 32'h55);
    step();
`ifdef RFW_PENDING_EN
    n_assert++;
    if (pending[5] !== 1'b1) begin
      n_fail++; $display("FAIL cancel_pending_set: got %b expected 1", pending[5]);
    end
`endif
    set_alu(1'b1, 5'd5, 32'h99); set_ld(1'b0, 5'd0, 32'd0);
    step();
`ifdef RFW_PENDING_EN
    n_assert++;
    if (pending[5] !== 1'b0) begin
      n_fail++; $display("FAIL cancel_pending_clr: got %b expected 0", pending[5]);
    end
`endif
    idle_inputs();
    step();
    n_assert++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL cancel_dead_pop: got %b expected 0", reg_write);
    end
    n_assert++;
    if (rf_obs[5] !== 32'h99) begin
      n_fail++; $display("FAIL cancel_final_x5: got %h expected 99", rf_obs[5]);
    end
  endtask

  task automatic test_full_reset();
    int late_writes;
    for (int k = 0; k < DEPTH; k++) begin
      set_alu(1'b1, 5'd1, 32'(k)); set_ld(1'b1, 5'(11 + k), 32'hA00 + k);
      step();
    end
    n_assert++;
    if (ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b expected 0", ld_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (ld_ready !== 1'b1 || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got ready=%b write=%b expected 1/0", ld_ready, reg_write);
    end
`ifdef RFW_PENDING_EN
    n_assert++;
    if (pending !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_pending: got %h expected 0", pending);
    end
`endif
    model_reset();
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    late_writes = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (reg_write === 1'b1) late_writes++;
    end
    n_assert++;
    if (late_writes != 0) begin
      n_fail++; $display("FAIL reset_no_writes: got %0d expected 0", late_writes);
    end
  endtask

  task automatic test_x0();
    set_alu(1'b1, 5'd0, 32'hDEAD); set_ld(1'b1, 5'd0, 32'hBEEF);
    step();
    n_assert++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL x0_alu: got %b expected 0", reg_write);
    end
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    n_assert++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL x0_bypass: got %b expected 0", reg_write);
    end
    set_alu(1'b1, 5'd2, 32'h22); set_ld(1'b1, 5'd6, 32'h66);
    step();
    set_alu(1'b1, 5'd0, 32'h1); set_ld(1'b1, 5'd0, 32'h2);
    step();
    idle_inputs();
    step();
    n_assert++;
    if (reg_write !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'h66) begin
      n_fail++; $display("FAIL x0_occupancy: got %b x%0d=%h expected x6=66", reg_write, write_reg, write_data);
    end
    step();
    n_assert++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL x0_queue_empty: got %b expected 0", reg_write);
    end
  endtask

  task automatic test_random();
    int p_alu;
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      p_alu = ((c / 300) % 2 == 1) ? 90 : 45;
      if (!(alu_valid && exp_stall))
        set_alu($urandom_range(0, 99) < p_alu, 5'($urandom_range(0, 7)), $urandom);
      if (!(ld_valid && !exp_ready))
        set_ld($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (rf_obs[i]) rf_obs[i] = 32'd0;
    exp_stall = 1'b0;
    exp_ready = 1'b1;
    test_reset();
    test_priority();
    test_bypass();
    test_starvation();
    test_cancel();
    test_full_reset();
    test_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
